// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply memory master: state encoding,
// datapath widths and the row-major element address helper.
package matmul_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Word address of element [row][col] of an n-column row-major matrix at base.
  function automatic word_t elem_addr(input word_t base, input cnt_t row,
                                      input cnt_t col, input word_t n);
    return base + word_t'(row) * n + word_t'(col);
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Combinational multiply-accumulate step: acc_next = acc + a * b.
// Build option MATMUL_SATURATE_EN clamps the result at 32'hFFFF_FFFF instead of wrapping.
module matmul_mac
  import matmul_pkg::*;
(
  input  logic [WORD_W-1:0] acc,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] acc_next
);

`ifdef MATMUL_SATURATE_EN
  // Full 64-bit product plus 32-bit acc cannot exceed 2^64 - 2^32, so 64 bits suffice.
  logic [2*WORD_W-1:0] product;
  logic [2*WORD_W-1:0] sum;

  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    product  = {{WORD_W{1'b0}}, a} * {{WORD_W{1'b0}}, b};
    sum      = product + {{WORD_W{1'b0}}, acc};
    acc_next = (sum[2*WORD_W-1:WORD_W] != '0) ? '1 : sum[WORD_W-1:0];
  end
`else
  assign acc_next = acc + a * b;
`endif

endmodule

// File: rtl/matmul_mem_master.sv
// Bus initiator that reads N x N matrices A and B, computes C = A x B and writes C back.
// Saturating accumulation is selected with the MATMUL_SATURATE_EN macro (see matmul_mac).
module matmul_mem_master
  import matmul_pkg::*;
#(
  parameter int N      = 3,
  parameter int A_BASE = 0,
  parameter int B_BASE = 9,
  parameter int C_BASE = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] mem_address,
  output logic [WORD_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  input  logic [WORD_W-1:0] mem_read_data
);

  localparam cnt_t  LAST   = cnt_t'(N - 1);
  localparam word_t N_W    = word_t'(N);
  localparam word_t A_ADDR = word_t'(A_BASE);
  localparam word_t B_ADDR = word_t'(B_BASE);
  localparam word_t C_ADDR = word_t'(C_BASE);

  state_t state;
  cnt_t   i, j, k;
  word_t  acc;
  word_t  a_reg;
  word_t  acc_next;

  matmul_mac u_mac (
    .acc      (acc),
    .a        (a_reg),
    .b        (mem_read_data),
    .acc_next (acc_next)
  );

  // Outputs are registered: each transition loads the bus values for the state
  // being entered, so the memory sees a stable address for the whole cycle.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      i                <= '0;
      j                <= '0;
      k                <= '0;
      acc              <= '0;
      a_reg            <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state           <= S_RD_A;
            i               <= '0;
            j               <= '0;
            k               <= '0;
            acc             <= '0;
            busy            <= 1'b1;
            mem_read_enable <= 1'b1;
            mem_address     <= elem_addr(A_ADDR, '0, '0, N_W);
          end
        end

        S_RD_A: begin
          a_reg       <= mem_read_data;
          state       <= S_RD_B;
          mem_address <= elem_addr(B_ADDR, k, j, N_W);
        end

        S_RD_B: begin
          acc <= acc_next;
          if (k == LAST) begin
            state            <= S_WR;
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b1;
            mem_write_data   <= acc_next;
            mem_address      <= elem_addr(C_ADDR, i, j, N_W);
          end else begin
            k           <= cnt_t'(k + 1'b1);
            state       <= S_RD_A;
            mem_address <= elem_addr(A_ADDR, i, cnt_t'(k + 1'b1), N_W);
          end
        end

        S_WR: begin
          acc              <= '0;
          k                <= '0;
          mem_write_enable <= 1'b0;
          mem_write_data   <= '0;
          if (j != LAST) begin
            j               <= cnt_t'(j + 1'b1);
            state           <= S_RD_A;
            mem_read_enable <= 1'b1;
            mem_address     <= elem_addr(A_ADDR, i, '0, N_W);
          end else if (i != LAST) begin
            j               <= '0;
            i               <= cnt_t'(i + 1'b1);
            state           <= S_RD_A;
            mem_read_enable <= 1'b1;
            mem_address     <= elem_addr(A_ADDR, cnt_t'(i + 1'b1), '0, N_W);
          end else begin
            state       <= S_DONE;
            done        <= 1'b1;
            mem_address <= '0;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state            <= S_IDLE;
          busy             <= 1'b0;
          done             <= 1'b0;
          mem_address      <= '0;
          mem_write_data   <= '0;
          mem_write_enable <= 1'b0;
          mem_read_enable  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/matmul_mem_master.md
Name: matmul_mem_master

Overview:
- Bus initiator for the word-addressed data memory.
- Reads two N×N unsigned 32-bit matrices A and B from memory, computes C = A×B, and writes C back to memory.
- Drives the same address, write-data, write-enable and read-enable interface the data memory exposes.
- Sits between the control unit (start/done handshake) and the data memory port.

Parameters:
- N, 3, matrix dimension (1..15).
- A_BASE, 0, word address of A[0][0], row-major.
- B_BASE, 9, word address of B[0][0], row-major.
- C_BASE, 18, word address of C[0][0], row-major.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- busy  output  1  high in every state except IDLE.
- done  output  1  single-cycle pulse when the last C word has been written.
- mem_address  output  32  word address to the data memory.
- mem_write_data  output  32  data for memory writes.
- mem_write_enable  output  1  memory write strobe; memory commits on the clk edge.
- mem_read_enable  output  1  memory read strobe.
- mem_read_data  input  32  combinational read data, valid in the same cycle as address plus read_enable.

Behaviour:
- Reset, and the IDLE state, drive all outputs to 0 (busy, done, mem_address, mem_write_data, mem_write_enable, mem_read_enable).
- Reset also clears the counters i, j, k, the accumulator acc and the latch a_reg.
- Reset mid-operation aborts to IDLE on the next edge. Memory words already written stay written.
- States: IDLE, RD_A, RD_B, WR, DONE.
- IDLE:
  - start=1 clears i, j, k and acc, then moves to RD_A.
  - start=0 stays in IDLE.
- RD_A:
  - Drives mem_address = A_BASE + i*N + k and mem_read_enable=1.
  - Latches a_reg <= mem_read_data.
  - Moves to RD_B.
- RD_B:
  - Drives mem_address = B_BASE + k*N + j and mem_read_enable=1.
  - Updates acc <= acc + a_reg*mem_read_data, keeping the low 32 bits of the product and the sum.
  - If k == N-1, moves to WR. Otherwise k <= k+1 and moves to RD_A.
- WR:
  - Drives mem_address = C_BASE + i*N + j, mem_write_data = acc and mem_write_enable=1.
  - Then clears acc and k.
  - If j < N-1: j <= j+1.
  - Else if i < N-1: j <= 0 and i <= i+1.
  - Else moves to DONE; otherwise returns to RD_A.
- DONE: drives done=1 for exactly one cycle (busy still 1), then moves to IDLE.
- Enable exclusivity: mem_read_enable and mem_write_enable are never both 1. Outside RD_A, RD_B and WR, both are 0 and mem_address is 0.
- Latency: N*N*(2N+1) cycles in RD_A/RD_B/WR, plus 1 DONE cycle.
  - For N=3, the start edge is followed by 63 busy cycles, and done is high in the 64th cycle after the start edge.
- start while busy is ignored; no queuing.
- start held high through DONE causes a new run one cycle after returning to IDLE.
- Address arithmetic is 32-bit unsigned. Address ranges are not checked; overlapping C and A/B regions give defined but software-visible results.

Optional Feature:
- MATMUL_SATURATE_EN defined:
  - The product and the accumulate are computed at 64 bits.
  - Any result above 32'hFFFF_FFFF clamps acc to 32'hFFFF_FFFF, and the value stays clamped for the rest of that C element.
- Undefined: product and sum wrap modulo 2^32.

Decomposition:
- Shared package matmul_pkg holds:
  - the state encoding constants S_IDLE, S_RD_A, S_RD_B, S_WR, S_DONE (3-bit);
  - the 32-bit word-width constant;
  - the counter width (4 bits, sufficient for N ≤ 15).
- One sub-module, matmul_mac:
  - Combinational next-acc computation from acc, a_reg and mem_read_data.
  - Contains the MATMUL_SATURATE_EN logic so the FSM file stays macro-free.

Test Plan:
- Default preload: A and B words 0..17 = 1,2,3,1,2,3,1,2,3 each; pulse start.
  - Words 18..26 must equal 6,12,18,6,12,18,6,12,18.
  - done must pulse once, 64 cycles after the start edge; busy is high for cycles 1..64.
- Protocol monitor over the full run: every cycle has read_enable&write_enable=0; exactly 9 write strobes at addresses 18..26 in ascending order; exactly 54 read strobes.
- Start while busy: assert start at cycles 5 and 30.
  - There must be no restart, identical results, and a single done pulse.
- Reset mid-run: assert rst at cycle 20 for 1 cycle.
  - All outputs must be 0 next cycle and the FSM in IDLE.
  - A fresh start then reproduces the correct C.
- Overflow: A[0][0]=32'h0001_0000, B[0][0]=32'h0001_0000, rest 0.
  - Without the macro, C[0][0]=0.
  - With MATMUL_SATURATE_EN, C[0][0]=32'hFFFF_FFFF.
  - All other C words are 0 in both builds.
- Identity: B = identity, A = 1..9.
  - C must equal A (1..9); done timing is unchanged.
